// File: rtl/sysid_regbank_pkg.sv
// sysid_regbank_pkg
//   Shared constants for the system-ID / housekeeping register bank:
//   word addresses of the register map, CONTROL bit positions, the block
//   VERSION and the CAPS word packing helper.
package sysid_regbank_pkg;

  // Word addresses of the register map.
  localparam int unsigned ADDR_SYSID     = 0;
  localparam int unsigned ADDR_TSTAMP    = 1;
  localparam int unsigned ADDR_CAPS      = 2;
  localparam int unsigned ADDR_UPTIME_LO = 3;
  localparam int unsigned ADDR_UPTIME_HI = 4;
  localparam int unsigned ADDR_CONTROL   = 5;
  localparam int unsigned ADDR_SCRATCH0  = 6;

  // CONTROL register bit positions.
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  localparam logic [7:0] VERSION = 8'h02;

  // CAPS = {VERSION, NUM_SCRATCH, READ_LATENCY, 8'h00}
  function automatic logic [31:0] caps_word(input int unsigned num_scratch,
                                            input int unsigned read_latency);
    logic [7:0] ns;
    logic [7:0] rl;
    ns = 8'(num_scratch);
    rl = 8'(read_latency);
    return {VERSION, ns, rl, 8'h00};
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter
//   Prescaled 64-bit free-running uptime counter with a shadow latch for the
//   upper word, so software can read a coherent 64-bit value as LO then HI.
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   en         in   counter and prescaler advance only while high
//   clr        in   zero counter and prescaler on this edge (beats increment)
//   snap       in   latch count[63:32] into the shadow on this edge
//   count_lo   out  live count[31:0]
//   shadow_hi  out  shadow of count[63:32] taken at the last snap
module sysid_uptime_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] count_lo,
  output logic [31:0] shadow_hi
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [63:0]      count_q, count_d;
  logic [31:0]      shadow_q, shadow_d;

  always_comb begin
    pre_d    = pre_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    // Shadow samples the pre-edge value, matching the LO word captured
    // by the read pipeline on the same edge.
    if (snap) begin
      shadow_d = count_q[63:32];
    end
    if (clr) begin
      pre_d   = '0;
      count_d = '0;
    end else if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d   = '0;
        count_d = count_q + 64'd1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre_q    <= '0;
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      pre_q    <= pre_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  assign count_lo  = count_q[31:0];
  assign shadow_hi = shadow_q;

endmodule

// File: rtl/sysid_regbank.sv
// sysid_regbank
//   Avalon-MM system identification and housekeeping slave. Returns build
//   constants and a capability word, exposes a prescaled 64-bit uptime
//   counter with snapshot reads, and holds NUM_SCRATCH writable scratch
//   registers. Reads complete after a fixed READ_LATENCY (1 or 2).
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   address        in   word address
//   read / write   in   transfer strobes, one transfer per cycle
//   writedata      in   write data
//   byteenable     in   write byte lanes (ignored for reads)
//   readdata       out  read data, 0 whenever readdatavalid is low
//   readdatavalid  out  one pulse per accepted read
module sysid_regbank
  import sysid_regbank_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int unsigned NUM_SCRATCH  = 4,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  if (ADDR_SCRATCH0 + NUM_SCRATCH > 2 ** ADDR_W) begin : g_bad_map
    $error("sysid_regbank: NUM_SCRATCH does not fit in the address space");
  end
  if (NUM_SCRATCH < 1) begin : g_bad_scratch
    $error("sysid_regbank: NUM_SCRATCH must be at least 1");
  end
  if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick
    $error("sysid_regbank: TICK_DIV must be in 1..65535");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("sysid_regbank: READ_LATENCY must be 1 or 2");
  end

  localparam logic [31:0]       CAPS       = caps_word(NUM_SCRATCH, READ_LATENCY);
  localparam logic [ADDR_W-1:0] A_SYSID    = ADDR_W'(ADDR_SYSID);
  localparam logic [ADDR_W-1:0] A_TSTAMP   = ADDR_W'(ADDR_TSTAMP);
  localparam logic [ADDR_W-1:0] A_CAPS     = ADDR_W'(ADDR_CAPS);
  localparam logic [ADDR_W-1:0] A_UP_LO    = ADDR_W'(ADDR_UPTIME_LO);
  localparam logic [ADDR_W-1:0] A_UP_HI    = ADDR_W'(ADDR_UPTIME_HI);
  localparam logic [ADDR_W-1:0] A_CONTROL  = ADDR_W'(ADDR_CONTROL);

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic        ctrl_en_q, ctrl_en_d;
  logic        ctrl_wr;
  logic        clr;
  logic        snap;
  logic [31:0] count_lo;
  logic [31:0] shadow_hi;
  logic [31:0] rd_mux;
  logic        vld_p1_q, vld_p1_d;
  logic [31:0] data_p1_q, data_p1_d;
  logic        out_vld;
  logic [31:0] out_data;

  // CONTROL lives in byte lane 0 only; other lanes carry no state.
  assign ctrl_wr = write && (address == A_CONTROL) && byteenable[0];
  assign clr     = ctrl_wr && writedata[CTRL_CLR_BIT];
  assign snap    = read && (address == A_UP_LO);

  always_comb begin
    ctrl_en_d = ctrl_en_q;
    if (ctrl_wr) ctrl_en_d = writedata[CTRL_EN_BIT];
    for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
      scratch_d[i] = scratch_q[i];
      if (write && (address == ADDR_W'(ADDR_SCRATCH0 + i))) begin
        scratch_d[i] = be_merge(scratch_q[i], writedata, byteenable);
      end
    end
  end

  sysid_uptime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (ctrl_en_q),
    .clr       (clr),
    .snap      (snap),
    .count_lo  (count_lo),
    .shadow_hi (shadow_hi)
  );

  // Read mux sees only pre-edge register state, so a read concurrent with
  // a write returns the value before that write.
  always_comb begin
    rd_mux = '0;
    if (address == A_SYSID)          rd_mux = SYSTEM_ID;
    else if (address == A_TSTAMP)    rd_mux = TIMESTAMP;
    else if (address == A_CAPS)      rd_mux = CAPS;
    else if (address == A_UP_LO)     rd_mux = count_lo;
    else if (address == A_UP_HI)     rd_mux = shadow_hi;
    else if (address == A_CONTROL)   rd_mux = {31'd0, ctrl_en_q};
    else begin
      for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
        if (address == ADDR_W'(ADDR_SCRATCH0 + i)) rd_mux = scratch_q[i];
      end
    end
  end

  // Stage p1: capture read data at the accept edge.
  always_comb begin
    vld_p1_d  = read;
    data_p1_d = read ? rd_mux : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_SCRATCH); i++) scratch_q[i] <= '0;
      ctrl_en_q <= 1'b1;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SCRATCH); i++) scratch_q[i] <= scratch_d[i];
      ctrl_en_q <= ctrl_en_d;
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic        vld_p2_q, vld_p2_d;
    logic [31:0] data_p2_q, data_p2_d;

    // Stage p2: one extra register for the two-cycle latency build.
    always_comb begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = data_p1_q;
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        vld_p2_q  <= 1'b0;
        data_p2_q <= '0;
      end else begin
        vld_p2_q  <= vld_p2_d;
        data_p2_q <= data_p2_d;
      end
    end

    assign out_vld  = vld_p2_q;
    assign out_data = data_p2_q;
  end else begin : g_lat1
    assign out_vld  = vld_p1_q;
    assign out_data = data_p1_q;
  end

  assign readdatavalid = out_vld;
  assign readdata      = out_vld ? out_data : '0;

endmodule

// File: tb/tb_sysid_regbank.sv
module tb_sysid_regbank;

  localparam logic [31:0] SYS_ID = 32'hA5A5_0001;
  localparam logic [31:0] TSTAMP = 32'h6543_2100;
  localparam int          NSCR   = 4;
  localparam int          TDIV   = 4;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] rd1, rd2;
  logic        rdv1, rdv2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q1[$];
  exp_t q2[$];

  // Reference state, kept as plain numbers.
  logic [63:0] m_up;
  int          m_pre;
  bit          m_en;
  logic [31:0] m_shadow;
  logic [31:0] m_scr [NSCR];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sysid_regbank #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .NUM_SCRATCH(NSCR),
    .ADDR_W(4), .TICK_DIV(TDIV), .READ_LATENCY(1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rd1), .readdatavalid(rdv1)
  );

  sysid_regbank #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .NUM_SCRATCH(NSCR),
    .ADDR_W(4), .TICK_DIV(TDIV), .READ_LATENCY(2)
  ) dut2 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rd2), .readdatavalid(rdv2)
  );

  function automatic logic [31:0] model_read(input logic [3:0] a, input int lat);
    logic [7:0] l8;
    l8 = 8'(lat);
    case (a)
      4'd0: return SYS_ID;
      4'd1: return TSTAMP;
      4'd2: return {8'h02, 8'd4, l8, 8'h00};
      4'd3: return m_up[31:0];
      4'd4: return m_shadow;
      4'd5: return {31'd0, m_en};
      4'd6, 4'd7, 4'd8, 4'd9: return m_scr[a - 4'd6];
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive, predict, clock, advance the reference.
  task automatic tick(input bit rst, input bit rd, input bit wr, input logic [3:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    bit ctrl_w;
    reset_n = !rst; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    if (rd && !rst) begin
      q1.push_back('{model_read(a, 1), cyc + 1});
      q2.push_back('{model_read(a, 2), cyc + 2});
    end
    @(posedge clock);
    if (rst) begin
      m_up = 0; m_pre = 0; m_en = 1'b1; m_shadow = 0;
      for (int i = 0; i < NSCR; i++) m_scr[i] = 0;
    end else begin
      ctrl_w = wr && (a == 4'd5) && be[0];
      if (rd && a == 4'd3) m_shadow = m_up[63:32];
      if (ctrl_w && wd[1]) begin
        m_up = 0; m_pre = 0;
      end else if (m_en) begin
        if (m_pre == TDIV - 1) begin m_pre = 0; m_up = m_up + 1; end
        else m_pre = m_pre + 1;
      end
      if (ctrl_w) m_en = wd[0];
      if (wr && a >= 4'd6 && a <= 4'd9)
        for (int b = 0; b < 4; b++)
          if (be[b]) m_scr[a - 4'd6][8*b +: 8] = wd[8*b +: 8];
    end
    #1;
    if (rst) begin q1.delete(); q2.delete(); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 4'd0, 32'h0, 4'h0);
  endtask

  task automatic rd_word(input logic [3:0] a);
    tick(0, 1, 0, a, 32'h0, 4'h0);
  endtask

  task automatic wr_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    tick(0, 0, 1, a, d, be);
  endtask

  // Monitor for the latency-1 instance.
  exp_t e1;
  always @(negedge clock) begin
    checks++;
    if (rdv1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL lat1_spurious: readdatavalid=1 data=%h at cycle %0d, no read expected", rd1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (rd1 !== e1.data || cyc != e1.due) begin
          errors++;
          $display("FAIL lat1_read: got %h at cycle %0d, expected %h at cycle %0d", rd1, cyc, e1.data, e1.due);
        end
      end
    end else begin
      if (rd1 !== 32'h0) begin
        errors++;
        $display("FAIL lat1_idle_data: readdata=%h while invalid, expected 0", rd1);
      end
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        e1 = q1.pop_front();
        errors++;
        $display("FAIL lat1_missing: no valid at cycle %0d, expected %h", cyc, e1.data);
      end
    end
  end

  // Monitor for the latency-2 instance.
  exp_t e2;
  always @(negedge clock) begin
    checks++;
    if (rdv2) begin
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL lat2_spurious: readdatavalid=1 data=%h at cycle %0d, no read expected", rd2, cyc);
      end else begin
        e2 = q2.pop_front();
        if (rd2 !== e2.data || cyc != e2.due) begin
          errors++;
          $display("FAIL lat2_read: got %h at cycle %0d, expected %h at cycle %0d", rd2, cyc, e2.data, e2.due);
        end
      end
    end else begin
      if (rd2 !== 32'h0) begin
        errors++;
        $display("FAIL lat2_idle_data: readdata=%h while invalid, expected 0", rd2);
      end
      if (q2.size() > 0 && q2[0].due <= cyc) begin
        e2 = q2.pop_front();
        errors++;
        $display("FAIL lat2_missing: no valid at cycle %0d, expected %h", cyc, e2.data);
      end
    end
  end

  initial begin
    reset_n = 1'b0; read = 0; write = 0; address = 0; writedata = 0; byteenable = 0;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 4'd0, 32'h0, 4'h0);

    // Identity words, back to back.
    rd_word(4'd0); rd_word(4'd1); rd_word(4'd2);
    idle(3);

    // Scratch byte enables, unmapped address.
    wr_word(4'd6, 32'hDEAD_BEEF, 4'b0101);
    rd_word(4'd6);
    rd_word(4'd15);
    wr_word(4'd15, 32'h1234_5678, 4'hF);
    rd_word(4'd15);
    // Read and write the same scratch in one cycle: old value returned.
    tick(0, 1, 1, 4'd7, 32'hCAFE_F00D, 4'hF);
    rd_word(4'd7);
    rd_word(4'd5);

    // Let uptime run, then freeze it.
    idle(28);
    rd_word(4'd3);
    wr_word(4'd5, 32'h0, 4'h1);
    idle(20);
    rd_word(4'd3);
    rd_word(4'd5);

    // Put the counter at the 32-bit boundary while frozen.
    force dut1.u_uptime.count_q = 64'h0000_0000_FFFF_FFFF;
    force dut2.u_uptime.count_q = 64'h0000_0000_FFFF_FFFF;
    idle(1);
    release dut1.u_uptime.count_q;
    release dut2.u_uptime.count_q;
    m_up = 64'h0000_0000_FFFF_FFFF;
    idle(1);
    rd_word(4'd3);
    rd_word(4'd4);
    wr_word(4'd5, 32'h1, 4'h1);
    idle(TDIV + 1);
    rd_word(4'd4);
    rd_word(4'd3);
    rd_word(4'd4);

    // CLR with a concurrent CONTROL read: old value returned, then restarted.
    idle(7);
    tick(0, 1, 1, 4'd5, 32'h3, 4'h1);
    rd_word(4'd3);
    rd_word(4'd5);
    // CLR with byteenable[0]=0 does nothing.
    idle(5);
    wr_word(4'd5, 32'h2, 4'b1110);
    rd_word(4'd3);

    // Randomised traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  ra;
      logic [31:0] rw;
      ra = 4'($urandom_range(0, 15));
      rw = $urandom;
      if (ra == 4'd5 && $urandom_range(0, 3) != 0) rw[0] = 1'b1;
      tick(0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, ra, rw,
           4'($urandom_range(0, 15)));
    end
    idle(3);

    // Back-to-back reads, then reset with reads still in flight.
    rd_word(4'd0); rd_word(4'd2); rd_word(4'd6);
    tick(1, 1, 0, 4'd1, 32'h0, 4'h0);
    tick(1, 0, 0, 4'd0, 32'h0, 4'h0);
    idle(4);
    rd_word(4'd5);
    rd_word(4'd6);
    idle(4);

    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d reads still outstanding, expected 0/0", q1.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
